// File: rtl/mold_pkg.sv
// Shared widths, table entry layout and header classification for the
// MoldUDP64 multi-session sequence tracker.
package mold_pkg;

  localparam int LEN       = 20;  // MoldUDP64 header bytes: sid + seq + count
  localparam int SID_W     = 80;
  localparam int SEQ_NUM_W = 64;
  localparam int ML_W      = 16;

  localparam logic [ML_W-1:0] EOS_MSG_CNT = 16'hffff;

  // LRU age is kept in mold_seq_lru, not in this entry.
  typedef struct packed {
    logic                 valid;
    logic [SID_W-1:0]     sid;
    logic [SEQ_NUM_W-1:0] exp_seq;
  } sess_entry_t;

  typedef enum logic [2:0] {
    INORDER,
    GAP,
    DUP,
    OVERLAP,
    EOS,
    NEW
  } seq_class_t;

  function automatic logic is_eos(input logic [ML_W-1:0] msg_cnt);
    return msg_cnt == EOS_MSG_CNT;
  endfunction

endpackage

// File: rtl/mold_seq_lru.sv
// LRU age tracker: ages form a permutation of 0..N_SESS-1, 0 = most recent.
// The victim is the entry whose age is N_SESS-1.
module mold_seq_lru #(
  parameter int N_SESS = 4,
  parameter int IDX_W  = $clog2(N_SESS)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             touch_v,
  input  logic [IDX_W-1:0] touch_idx,
  output logic [IDX_W-1:0] victim_idx
);

  logic [IDX_W-1:0] age_q [N_SESS];
  logic [IDX_W-1:0] touch_age;

  assign touch_age = age_q[touch_idx];

  always_comb begin
    victim_idx = '0;
    for (int i = 0; i < N_SESS; i++) begin
      if (age_q[i] == IDX_W'(N_SESS - 1)) begin
        victim_idx = IDX_W'(i);
      end
    end
  end

  // Only entries younger than the touched one move, so the permutation holds.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < N_SESS; i++) begin
        age_q[i] <= IDX_W'(i);
      end
    end else if (touch_v) begin
      for (int i = 0; i < N_SESS; i++) begin
        if (IDX_W'(i) == touch_idx) begin
          age_q[i] <= '0;
        end else if (age_q[i] < touch_age) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/moldudp64_seq_track.sv
// Multi-session MoldUDP64 sequence tracker: per-header classification into
// in-order, gap, duplicate, overlap, end-of-session or new session, 1-cycle latency.
module moldudp64_seq_track
  import mold_pkg::*;
#(
  parameter int N_SESS = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 flush_i,
  input  logic                 hdr_v_i,
  input  logic [SID_W-1:0]     hdr_sid_i,
  input  logic [SEQ_NUM_W-1:0] hdr_seq_num_i,
  input  logic [ML_W-1:0]      hdr_msg_cnt_i,
  output logic                 acc_v_o,
  output logic [ML_W-1:0]      acc_skip_o,
  output logic                 dup_v_o,
  output logic                 miss_v_o,
  output logic [SID_W-1:0]     miss_sid_o,
  output logic [SEQ_NUM_W-1:0] miss_seq_start_o,
  output logic [SEQ_NUM_W-1:0] miss_seq_cnt_o,
  output logic                 new_sid_v_o,
  output logic                 evict_v_o,
  output logic [SID_W-1:0]     evict_sid_o,
  output logic                 eos_v_o
);

  localparam int IDX_W = $clog2(N_SESS);

  sess_entry_t          tbl_q [N_SESS];
  logic                 hit;
  logic                 any_free;
  logic [IDX_W-1:0]     hit_idx;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     victim_idx;
  logic [IDX_W-1:0]     alloc_idx;
  logic [IDX_W-1:0]     tgt_idx;
  logic [SEQ_NUM_W-1:0] exp_seq;
  logic [SEQ_NUM_W-1:0] cnt_ext;
  logic [SEQ_NUM_W-1:0] end_seq;
  seq_class_t           seq_cls;
  logic                 hdr_go;
  logic                 touch_v;

  assign hdr_go = hdr_v_i && !flush_i;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < N_SESS; i++) begin
      if (!hit && tbl_q[i].valid && (tbl_q[i].sid == hdr_sid_i)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Descending scan leaves the lowest free index selected.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = N_SESS - 1; i >= 0; i--) begin
      if (!tbl_q[i].valid) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign alloc_idx = any_free ? free_idx : victim_idx;
  assign tgt_idx   = hit ? hit_idx : alloc_idx;
  assign exp_seq   = tbl_q[hit_idx].exp_seq;
  assign cnt_ext   = {{(SEQ_NUM_W - ML_W){1'b0}}, hdr_msg_cnt_i};
  assign end_seq   = hdr_seq_num_i + cnt_ext;

  always_comb begin
    seq_cls = NEW;
    if (hit) begin
      if (is_eos(hdr_msg_cnt_i)) begin
        seq_cls = EOS;
      end else if (hdr_seq_num_i == exp_seq) begin
        seq_cls = INORDER;
      end else if (hdr_seq_num_i > exp_seq) begin
        seq_cls = GAP;
      end else if (end_seq <= exp_seq) begin
        seq_cls = DUP;
      end else begin
        seq_cls = OVERLAP;
      end
    end else if (is_eos(hdr_msg_cnt_i)) begin
      seq_cls = EOS;
    end
  end

  // An EOS for an unknown session touches nothing; every hit is a touch.
  assign touch_v = hdr_go && (hit || (seq_cls == NEW));

  mold_seq_lru #(
    .N_SESS (N_SESS),
    .IDX_W  (IDX_W)
  ) u_lru (
    .clk        (clk),
    .nreset     (nreset),
    .touch_v    (touch_v),
    .touch_idx  (tgt_idx),
    .victim_idx (victim_idx)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < N_SESS; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < N_SESS; i++) begin
        tbl_q[i].valid <= 1'b0;
      end
    end else if (hdr_go) begin
      case (seq_cls)
        INORDER, GAP, OVERLAP: tbl_q[tgt_idx].exp_seq <= end_seq;
        EOS: begin
          if (hit) begin
            tbl_q[tgt_idx].valid <= 1'b0;
          end
        end
        NEW: tbl_q[tgt_idx] <= '{valid: 1'b1, sid: hdr_sid_i, exp_seq: end_seq};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc_v_o          <= 1'b0;
      acc_skip_o       <= '0;
      dup_v_o          <= 1'b0;
      miss_v_o         <= 1'b0;
      miss_sid_o       <= '0;
      miss_seq_start_o <= '0;
      miss_seq_cnt_o   <= '0;
      new_sid_v_o      <= 1'b0;
      evict_v_o        <= 1'b0;
      evict_sid_o      <= '0;
      eos_v_o          <= 1'b0;
    end else begin
      acc_v_o     <= 1'b0;
      dup_v_o     <= 1'b0;
      miss_v_o    <= 1'b0;
      new_sid_v_o <= 1'b0;
      evict_v_o   <= 1'b0;
      eos_v_o     <= 1'b0;
      if (hdr_go) begin
        case (seq_cls)
          INORDER: begin
            acc_v_o    <= 1'b1;
            acc_skip_o <= '0;
          end
          GAP: begin
            acc_v_o          <= 1'b1;
            acc_skip_o       <= '0;
            miss_v_o         <= 1'b1;
            miss_sid_o       <= hdr_sid_i;
            miss_seq_start_o <= exp_seq;
            miss_seq_cnt_o   <= hdr_seq_num_i - exp_seq;
          end
          DUP: dup_v_o <= 1'b1;
          OVERLAP: begin
            acc_v_o    <= 1'b1;
            acc_skip_o <= ML_W'(exp_seq - hdr_seq_num_i);
          end
          EOS: eos_v_o <= 1'b1;
          NEW: begin
            acc_v_o     <= 1'b1;
            acc_skip_o  <= '0;
            new_sid_v_o <= 1'b1;
            if (!any_free) begin
              evict_v_o   <= 1'b1;
              evict_sid_o <= tbl_q[victim_idx].sid;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moldudp64_seq_track.sv
// Directed vector bench for moldudp64_seq_track: a table of headers with
// hand-computed responses, plus a hand-written mid-stream reset sequence.
module tb_moldudp64_seq_track;

  logic        clk;
  logic        nreset;
  logic        flush_i;
  logic        hdr_v_i;
  logic [79:0] hdr_sid_i;
  logic [63:0] hdr_seq_num_i;
  logic [15:0] hdr_msg_cnt_i;
  logic        acc_v_o;
  logic [15:0] acc_skip_o;
  logic        dup_v_o;
  logic        miss_v_o;
  logic [79:0] miss_sid_o;
  logic [63:0] miss_seq_start_o;
  logic [63:0] miss_seq_cnt_o;
  logic        new_sid_v_o;
  logic        evict_v_o;
  logic [79:0] evict_sid_o;
  logic        eos_v_o;

  int n_tests = 0;
  int n_fail  = 0;

  moldudp64_seq_track #(.N_SESS(4)) dut (
    .clk              (clk),
    .nreset           (nreset),
    .flush_i          (flush_i),
    .hdr_v_i          (hdr_v_i),
    .hdr_sid_i        (hdr_sid_i),
    .hdr_seq_num_i    (hdr_seq_num_i),
    .hdr_msg_cnt_i    (hdr_msg_cnt_i),
    .acc_v_o          (acc_v_o),
    .acc_skip_o       (acc_skip_o),
    .dup_v_o          (dup_v_o),
    .miss_v_o         (miss_v_o),
    .miss_sid_o       (miss_sid_o),
    .miss_seq_start_o (miss_seq_start_o),
    .miss_seq_cnt_o   (miss_seq_cnt_o),
    .new_sid_v_o      (new_sid_v_o),
    .evict_v_o        (evict_v_o),
    .evict_sid_o      (evict_sid_o),
    .eos_v_o          (eos_v_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        flush;
    logic [79:0] sid;
    logic [63:0] seq;
    logic [15:0] cnt;
    logic        acc;
    logic [15:0] skip;
    logic        dup;
    logic        miss;
    logic [63:0] mstart;
    logic [63:0] mcnt;
    logic        nw;
    logic        ev;
    logic [79:0] evsid;
    logic        eos;
  } vec_t;

  vec_t vq[$];

  localparam logic [79:0] S1 = 80'hDEADBEEF;
  localparam logic [79:0] SA = 80'hA1;
  localparam logic [79:0] SB = 80'hB2;
  localparam logic [79:0] SC = 80'hC3;
  localparam logic [79:0] SD = 80'hD4;
  localparam logic [79:0] SX = 80'hE5;
  localparam logic [79:0] SY = 80'hF6;

  function automatic vec_t mk(input logic fl, input logic [79:0] sid, input logic [63:0] seq,
                              input logic [15:0] cnt, input logic acc, input logic [15:0] skip,
                              input logic dup, input logic miss, input logic [63:0] ms,
                              input logic [63:0] mc, input logic nw, input logic ev,
                              input logic [79:0] evsid, input logic eos);
    vec_t v;
    v.flush = fl;  v.sid = sid;   v.seq = seq;   v.cnt = cnt;
    v.acc = acc;   v.skip = skip; v.dup = dup;   v.miss = miss;
    v.mstart = ms; v.mcnt = mc;   v.nw = nw;     v.ev = ev;
    v.evsid = evsid; v.eos = eos;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_pulses(input string tag, input logic acc, input logic dup, input logic miss,
                            input logic nw, input logic ev, input logic eos);
    chk({tag, " acc_v"}, 80'(acc_v_o), 80'(acc));
    chk({tag, " dup_v"}, 80'(dup_v_o), 80'(dup));
    chk({tag, " miss_v"}, 80'(miss_v_o), 80'(miss));
    chk({tag, " new_sid_v"}, 80'(new_sid_v_o), 80'(nw));
    chk({tag, " evict_v"}, 80'(evict_v_o), 80'(ev));
    chk({tag, " eos_v"}, 80'(eos_v_o), 80'(eos));
  endtask

  task automatic drive(input logic fl, input logic v, input logic [79:0] sid,
                       input logic [63:0] seq, input logic [15:0] cnt);
    flush_i = fl; hdr_v_i = v; hdr_sid_i = sid; hdr_seq_num_i = seq; hdr_msg_cnt_i = cnt;
  endtask

  initial begin
    //         fl  sid seq    cnt       acc skip dup miss mstart mcnt nw ev evsid eos
    vq.push_back(mk(0, S1, 100, 16'd3, 1, 0, 0, 0, 0,   0, 1, 0, 0,  0));
    vq.push_back(mk(0, S1, 103, 16'd2, 1, 0, 0, 0, 0,   0, 0, 0, 0,  0));
    vq.push_back(mk(0, S1, 110, 16'd1, 1, 0, 0, 1, 105, 5, 0, 0, 0,  0));
    vq.push_back(mk(0, S1, 111, 16'd0, 1, 0, 0, 0, 0,   0, 0, 0, 0,  0));
    vq.push_back(mk(0, S1, 108, 16'd2, 0, 0, 1, 0, 0,   0, 0, 0, 0,  0));
    vq.push_back(mk(0, S1, 109, 16'd4, 1, 2, 0, 0, 0,   0, 0, 0, 0,  0));
    vq.push_back(mk(0, S1, 113, 16'd1, 1, 0, 0, 0, 0,   0, 0, 0, 0,  0));
    vq.push_back(mk(0, SA, 1000, 16'd1, 1, 0, 0, 0, 0,  0, 1, 0, 0,  0));
    vq.push_back(mk(0, SB, 2000, 16'd1, 1, 0, 0, 0, 0,  0, 1, 0, 0,  0));
    vq.push_back(mk(0, SC, 49,  16'd1, 1, 0, 0, 0, 0,   0, 1, 0, 0,  0));
    vq.push_back(mk(0, SD, 3000, 16'd1, 1, 0, 0, 0, 0,  0, 1, 1, S1, 0));
    vq.push_back(mk(0, S1, 500, 16'd1, 1, 0, 0, 0, 0,   0, 1, 1, SA, 0));
    vq.push_back(mk(0, SC, 50,  16'd0, 1, 0, 0, 0, 0,   0, 0, 0, 0,  0));
    vq.push_back(mk(0, SC, 50,  16'd2, 1, 0, 0, 0, 0,   0, 0, 0, 0,  0));
    vq.push_back(mk(0, SC, 0,   16'hffff, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, SC, 60,  16'd1, 1, 0, 0, 0, 0,   0, 1, 0, 0,  0));
    vq.push_back(mk(0, SX, 0,   16'hffff, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, SX, 5,   16'd1, 1, 0, 0, 0, 0,   0, 1, 1, SB, 0));
    vq.push_back(mk(1, SX, 6,   16'd1, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0));
    vq.push_back(mk(0, SX, 6,   16'd1, 1, 0, 0, 0, 0,   0, 1, 0, 0,  0));
    vq.push_back(mk(0, SD, 3001, 16'd1, 1, 0, 0, 0, 0,  0, 1, 0, 0,  0));

    nreset = 1'b0;
    drive(0, 0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk_pulses("reset", 0, 0, 0, 0, 0, 0);
    chk("reset acc_skip", 80'(acc_skip_o), 80'd0);
    chk("reset evict_sid", evict_sid_o, 80'd0);
    @(negedge clk);
    nreset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].flush, 1'b1, vq[i].sid, vq[i].seq, vq[i].cnt);
      @(posedge clk);
      #1;
      chk_pulses($sformatf("v%0d", i), vq[i].acc, vq[i].dup, vq[i].miss,
                 vq[i].nw, vq[i].ev, vq[i].eos);
      if (vq[i].acc) chk($sformatf("v%0d acc_skip", i), 80'(acc_skip_o), 80'(vq[i].skip));
      if (vq[i].miss) begin
        chk($sformatf("v%0d miss_sid", i), miss_sid_o, vq[i].sid);
        chk($sformatf("v%0d miss_start", i), 80'(miss_seq_start_o), 80'(vq[i].mstart));
        chk($sformatf("v%0d miss_cnt", i), 80'(miss_seq_cnt_o), 80'(vq[i].mcnt));
      end
      if (vq[i].ev) chk($sformatf("v%0d evict_sid", i), evict_sid_o, vq[i].evsid);
    end

    // Idle cycle: pulses must drop, miss data must hold its last value.
    @(negedge clk);
    drive(0, 0, '0, '0, '0);
    @(posedge clk);
    #1;
    chk_pulses("idle", 0, 0, 0, 0, 0, 0);
    chk("idle miss_start hold", 80'(miss_seq_start_o), 80'd105);

    // Mid-stream reset: allocate SY, then reset with a header in flight.
    @(negedge clk);
    drive(0, 1, SY, 64'd7, 16'd1);
    @(posedge clk);
    #1;
    chk_pulses("rst pre", 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    drive(0, 1, SY, 64'd8, 16'd1);
    #2;
    nreset = 1'b0;
    #1;
    chk("rst async acc_v", 80'(acc_v_o), 80'd0);
    @(posedge clk);
    #1;
    chk_pulses("rst inflight", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nreset = 1'b1;
    drive(0, 1, SY, 64'd8, 16'd1);
    @(posedge clk);
    #1;
    chk_pulses("rst post SY", 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    drive(0, 1, S1, 64'd600, 16'd1);
    @(posedge clk);
    #1;
    chk_pulses("rst post S1", 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, '0, '0, '0);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/moldudp64_seq_track.md
Name: moldudp64_seq_track

Overview:
- Multi-session sequence tracker placed after the MoldUDP64 header parser.
- Holds expected next sequence number for up to N_SESS concurrent session IDs, with LRU replacement.
- Per packet header it classifies: in-order, gap, full duplicate, partial overlap, or end-of-session.
- Successor to the single-session miss detection: adds multiple channels, duplicate/overlap filtering and eviction.

Parameters:
SID_W, 80, session id width (10 bytes)
SEQ_NUM_W, 64, sequence number width
ML_W, 16, message count width
N_SESS, 4, tracked sessions (power of 2, >=2)
EOS_MSG_CNT, 16'hffff, message count marking end of session

Ports:
clk  in  1  clock
nreset  in  1  asynchronous active-low reset
flush_i  in  1  invalidate all table entries
hdr_v_i  in  1  header valid, one cycle per packet
hdr_sid_i  in  SID_W  packet session id
hdr_seq_num_i  in  SEQ_NUM_W  packet first sequence number
hdr_msg_cnt_i  in  ML_W  packet message count
acc_v_o  out  1  packet accepted (forward messages)
acc_skip_o  out  ML_W  leading messages to drop (overlap)
dup_v_o  out  1  packet fully duplicate, drop
miss_v_o  out  1  gap detected
miss_sid_o  out  SID_W  gap session id
miss_seq_start_o  out  SEQ_NUM_W  first missing seq num
miss_seq_cnt_o  out  SEQ_NUM_W  missing count
new_sid_v_o  out  1  session newly allocated
evict_v_o  out  1  allocation evicted a live entry
evict_sid_o  out  SID_W  evicted session id
eos_v_o  out  1  end-of-session received, entry freed

Behaviour:
- Reset: nreset low clears all entries (valid=0, ages = index) and all outputs to 0 asynchronously. Mid-operation reset discards the in-flight header.
- Table entry: {valid, sid, exp_seq, age}.
- Lookup is combinational against hdr_sid_i; the table updates at the same edge that registers outputs.
  - Latency is 1 cycle.
  - Back-to-back headers, including same SID, are handled every cycle with no stall.
- All _v_o outputs are single-cycle pulses. Data outputs hold their last value when not valid.
- flush_i has priority over hdr_v_i in the same cycle: header ignored, no pulses, all entries invalid next cycle.
- Arithmetic: unsigned, modulo 2^SEQ_NUM_W. msg_cnt is zero-extended. Let end = seq + msg_cnt.
- Hit, msg_cnt == EOS_MSG_CNT: eos_v_o=1, entry valid cleared, no accept, no gap check.
- Hit, seq == exp:
  - acc_v_o=1, acc_skip_o=0, exp <= end.
  - msg_cnt=0 (heartbeat) is accepted and leaves exp unchanged.
- Hit, seq > exp:
  - miss_v_o=1, miss_sid_o=sid, miss_seq_start_o=exp, miss_seq_cnt_o=seq-exp.
  - acc_v_o=1, exp <= end.
- Hit, seq < exp, end <= exp: dup_v_o=1, exp unchanged.
- Hit, seq < exp, end > exp: acc_v_o=1, acc_skip_o=exp-seq, exp <= end.
- Miss, msg_cnt == EOS_MSG_CNT: eos_v_o=1, nothing allocated.
- Miss, other msg_cnt:
  - Allocate the lowest-index invalid entry; if none, evict the LRU entry and pulse evict_v_o with evict_sid_o.
  - new_sid_v_o=1, acc_v_o=1, exp <= end. No gap is reported on the first packet.
- LRU ages are a permutation of 0..N_SESS-1:
  - On hit or allocate, the touched entry's age becomes 0.
  - Entries younger than its old age increment.
  - The victim is the entry with age N_SESS-1.
  - EOS and dup also count as touches.
- Exactly one of acc_v_o, dup_v_o, eos_v_o pulses per accepted header. miss_v_o can only accompany acc_v_o.

Decomposition:
- Package mold_pkg holds LEN, SID_W, SEQ_NUM_W, ML_W, EOS_MSG_CNT, a sess_entry_t struct, and a seq_class_t enum (INORDER, GAP, DUP, OVERLAP, EOS, NEW).
- One sub-module, mold_seq_lru: N_SESS age registers, with touch index/valid in and victim index out.

Test Plan:
- New SID DEADBEEF seq 100 cnt 3, then seq 103 cnt 2 -> cycle 1 new_sid_v_o, acc_v_o; cycle 2 acc_v_o, skip 0, exp 105.
- Same SID seq 110 cnt 1 after exp 105 -> miss_v_o, start 105, cnt 5, acc_v_o; then seq 111 is in order.
- Exp 111: seq 108 cnt 2 -> dup_v_o only; then seq 109 cnt 4 -> acc_v_o, skip 2, exp 113.
- Five distinct SIDs with N_SESS=4, back-to-back -> 5th gives evict_v_o with evict_sid_o = 1st SID. Re-sending the 1st SID then gives new_sid_v_o.
- Heartbeat cnt 0 at exp 50 -> acc_v_o, exp stays 50. cnt 16'hffff -> eos_v_o, and the next packet on that SID gives new_sid_v_o.
- flush_i together with hdr_v_i, and nreset pulse mid-stream -> no output pulses, all SIDs reported new afterwards.
